// File: rtl/fifo_unload_fsm_if.sv
// Bundles the FIFO-side and stream-side handshake signals of fifo_unload_fsm.
// The design connects to the slave modport; the driver/monitor connects to master.
interface fifo_unload_fsm_if #(
  parameter int DW = 16
);
  logic          start;
  logic [6:0]    samp_max;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rden;
  logic [2:0]    rd_sel;
  logic [6:0]    samp;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          dready;
  logic          busy;
  logic          done;

  modport slave (
    input  start, samp_max, fifo_empty, fifo_dout, dready,
    output fifo_rden, rd_sel, samp, dout, dvalid, busy, done
  );

  modport master (
    output start, samp_max, fifo_empty, fifo_dout, dready,
    input  fifo_rden, rd_sel, samp, dout, dvalid, busy, done
  );
endinterface

// File: rtl/fifo_unload_fsm.sv
// Unloads (samp_max+1)*WPS words from a FWFT FIFO into a registered valid/ready stream.
// Define FIFO_UNLOAD_TMR_EN to triplicate the control registers with majority voting.
//
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_READ  | popping words, advancing rd_sel/samp
//   S_DRAIN | last word popped, waiting for it to be accepted
//   S_DONE  | one-cycle done pulse
module fifo_unload_fsm #(
  parameter int DW  = 16,
  parameter int WPS = 6
) (
  input  logic              clk,
  input  logic              rst_b,
  fifo_unload_fsm_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0] LAST_SEL = 3'(WPS - 1);

  state_t        state_v, state_d;
  logic [6:0]    samp_v, samp_d;
  logic [6:0]    smax_v, smax_d;
  logic [2:0]    rd_sel_v, rd_sel_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic          xfer;

  always_comb begin
    xfer     = (state_v == S_READ) && !bus.fifo_empty && (!dvalid_q || bus.dready) && !bus.start;
    state_d  = state_v;
    samp_d   = samp_v;
    smax_d   = smax_v;
    rd_sel_d = rd_sel_v;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;

    // A pop reloads the output register, so an accept in the same cycle keeps dvalid set.
    if (xfer) begin
      dout_d   = bus.fifo_dout;
      dvalid_d = 1'b1;
    end else if (dvalid_q && bus.dready) begin
      dvalid_d = 1'b0;
    end

    if (bus.start) begin
      state_d  = S_READ;
      samp_d   = '0;
      rd_sel_d = '0;
      smax_d   = bus.samp_max;
    end else begin
      case (state_v)
        S_READ: begin
          if (xfer) begin
            if (rd_sel_v < LAST_SEL) begin
              rd_sel_d = rd_sel_v + 3'd1;
            end else begin
              rd_sel_d = '0;
              if (samp_v != smax_v) samp_d  = samp_v + 7'd1;
              else                  state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: if (!dvalid_q || bus.dready) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_v;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

`ifdef FIFO_UNLOAD_TMR_EN
  state_t     state_q  [3];
  logic [6:0] samp_q   [3];
  logic [6:0] smax_q   [3];
  logic [2:0] rd_sel_q [3];

  // Every copy reloads from the voted next-state, so a single upset heals in one cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i]  <= S_IDLE;
        samp_q[i]   <= '0;
        smax_q[i]   <= '0;
        rd_sel_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i]  <= state_d;
        samp_q[i]   <= samp_d;
        smax_q[i]   <= smax_d;
        rd_sel_q[i] <= rd_sel_d;
      end
    end
  end

  assign state_v  = state_t'((state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) |
                             (state_q[1] & state_q[2]));
  assign samp_v   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign smax_v   = (smax_q[0] & smax_q[1]) | (smax_q[0] & smax_q[2]) | (smax_q[1] & smax_q[2]);
  assign rd_sel_v = (rd_sel_q[0] & rd_sel_q[1]) | (rd_sel_q[0] & rd_sel_q[2]) |
                    (rd_sel_q[1] & rd_sel_q[2]);
`else
  state_t     state_q;
  logic [6:0] samp_q;
  logic [6:0] smax_q;
  logic [2:0] rd_sel_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      samp_q   <= '0;
      smax_q   <= '0;
      rd_sel_q <= '0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      smax_q   <= smax_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  assign state_v  = state_q;
  assign samp_v   = samp_q;
  assign smax_v   = smax_q;
  assign rd_sel_v = rd_sel_q;
`endif

  assign bus.fifo_rden = xfer;
  assign bus.rd_sel    = rd_sel_v;
  assign bus.samp      = samp_v;
  assign bus.dout      = dout_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.busy      = (state_v != S_IDLE);
  assign bus.done      = (state_v == S_DONE);

endmodule

// File: tb/tb_fifo_unload_fsm.sv
// Self-checking bench for fifo_unload_fsm: FIFO model plus output scoreboard,
// table-driven readouts, randomized readouts and hand-written corner sequences.
module tb_fifo_unload_fsm;
  localparam int DW  = 16;
  localparam int WPS = 6;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  fifo_unload_fsm_if #(.DW(DW)) bus ();

  fifo_unload_fsm #(.DW(DW), .WPS(WPS)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct {
    int smax;
    int rmode;      // 0: always ready, 1: toggle, 2: random
    int emode;      // 0: no stalls, 1: random empty stalls
    int extra;      // words left in the FIFO beyond the readout
    int exp_words;
  } vec_t;

  vec_t vecs [5];

  int n_vec = 0;
  int n_fail = 0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  int g_rmode = 0, g_emode = 0;
  bit g_start = 1'b0;
  logic [6:0] g_smax = '0;
  bit force_stall = 1'b0, force_nrdy = 1'b0;
  int pops, accepted, done_cnt, cyc, last_acc_cyc, done_cyc, first_pop_cyc, last_pop_cyc;
  bit last_rden;
  logic [15:0] seq = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int n);
    logic [DW-1:0] w;
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      seq++;
      w = seq ^ 16'h5a00;
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic begin_readout(input int smax);
    g_start = 1'b1;
    g_smax = 7'(smax);
    pops = 0; accepted = 0; done_cnt = 0;
    last_acc_cyc = -10; done_cyc = -1; first_pop_cyc = 0; last_pop_cyc = 0;
  endtask

  // One clock: drive at edge+1, sample at edge+4, then advance to next edge+1.
  task automatic cycle();
    logic rdy;
    bus.start = g_start;
    bus.samp_max = g_smax;
    case (g_rmode)
      0: rdy = 1'b1;
      1: rdy = cyc[0];
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    if (force_nrdy) rdy = 1'b0;
    bus.dready = rdy;
    bus.fifo_empty = (fifo_q.size() == 0) || force_stall || (g_emode == 1 && $urandom_range(0, 3) == 0);
    bus.fifo_dout = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #3;
    last_rden = bus.fifo_rden;
    if (bus.fifo_rden) begin
      chk("rden_not_empty", 32'(bus.fifo_empty), 0);
      chk("rd_sel_at_pop", 32'(bus.rd_sel), pops % WPS);
      chk("samp_at_pop", 32'(bus.samp), pops / WPS);
      if (pops == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
    end
    if (bus.dvalid && bus.dready) begin
      if (exp_q.size() == 0) chk("word_extra", 1, 0);
      else                   chk("word_order", 32'(bus.dout), 32'(exp_q.pop_front()));
      accepted++;
      last_acc_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    g_start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    if (done_cnt == 0) chk({tag, "_timeout"}, 0, 1);
    else begin
      cycle();
      cycle();
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    g_rmode = v.rmode;
    g_emode = v.emode;
    load(v.exp_words + v.extra);
    begin_readout(v.smax);
    run_until_done(tag, 20000);
    chk({tag, "_words"}, accepted, v.exp_words);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_after_accept"}, done_cyc, last_acc_cyc + 1);
    chk({tag, "_fifo_left"}, fifo_q.size(), v.extra);
    chk({tag, "_samp_final"}, 32'(bus.samp), v.smax);
    chk({tag, "_busy_idle"}, 32'(bus.busy), 0);
    chk({tag, "_dvalid_idle"}, 32'(bus.dvalid), 0);
    if (v.rmode == 0 && v.emode == 0)
      chk({tag, "_back_to_back"}, last_pop_cyc - first_pop_cyc, v.exp_words - 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_dvalid"}, 32'(bus.dvalid), 0);
    chk({tag, "_dout"}, 32'(bus.dout), 0);
    chk({tag, "_samp"}, 32'(bus.samp), 0);
    chk({tag, "_rd_sel"}, 32'(bus.rd_sel), 0);
    chk({tag, "_rden"}, 32'(bus.fifo_rden), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n;
    vecs[0] = '{0,   0, 0, 2, 6};
    vecs[1] = '{2,   1, 0, 0, 18};
    vecs[2] = '{127, 0, 0, 1, 768};
    vecs[3] = '{5,   2, 1, 3, 36};
    vecs[4] = '{1,   1, 1, 0, 12};

    bus.start = 1'b0; bus.samp_max = '0; bus.fifo_empty = 1'b1;
    bus.fifo_dout = '0; bus.dready = 1'b0;
    cyc = 0;
    #1 rst_b = 1'b0;
    #2 chk_reset_outputs("reset");
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Empty stall mid-sample freezes position and pops.
    g_rmode = 0; g_emode = 0;
    load(6);
    begin_readout(0);
    cycle(); cycle(); cycle();
    force_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_no_rden", 32'(last_rden), 0);
      chk("stall_rd_sel", 32'(bus.rd_sel), 2);
      chk("stall_samp", 32'(bus.samp), 0);
    end
    force_stall = 1'b0;
    run_until_done("stall", 200);
    chk("stall_words", accepted, 6);
    chk("stall_done_pulses", done_cnt, 1);

    // Restart at samp=1, rd_sel=3 with a pending word held by dready=0.
    g_rmode = 0; g_emode = 0;
    load(30);
    begin_readout(1);
    n = 0;
    while (pops < 9 && n < 100) begin
      cycle();
      n++;
    end
    chk("restart_reach_pos", pops, 9);
    force_nrdy = 1'b1;
    g_start = 1'b1;
    g_smax = 7'd0;
    cycle();
    chk("restart_no_pop", 32'(last_rden), 0);
    chk("restart_samp", 32'(bus.samp), 0);
    chk("restart_rd_sel", 32'(bus.rd_sel), 0);
    chk("restart_dvalid", 32'(bus.dvalid), 1);
    chk("restart_pending_word", 32'(bus.dout), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hffffffff);
    force_nrdy = 1'b0;
    pops = 0;
    run_until_done("restart", 200);
    chk("restart_words", accepted, 15);
    chk("restart_done_pulses", done_cnt, 1);
    chk("restart_fifo_left", fifo_q.size(), 15);

    // Asynchronous reset pulse mid-read.
    g_rmode = 0; g_emode = 0;
    load(30);
    begin_readout(3);
    for (int i = 0; i < 10; i++) cycle();
    #2 rst_b = 1'b0;
    #1 chk_reset_outputs("async_rst");
    rst_b = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    done_cnt = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) cycle();
    chk("async_rst_no_done", done_cnt, 0);
    chk("async_rst_busy", 32'(bus.busy), 0);

`ifdef FIFO_UNLOAD_TMR_EN
    g_rmode = 0; g_emode = 0;
    load(12);
    begin_readout(1);
    for (int i = 0; i < 4; i++) cycle();
    force dut.state_q[1] = 2'd2;
    #1;
    release dut.state_q[1];
    cycle();
    chk("tmr_rden", 32'(last_rden), 1);
    chk("tmr_busy", 32'(bus.busy), 1);
    chk("tmr_resync", 32'(dut.state_q[1]), 32'(dut.state_q[0]));
    run_until_done("tmr", 200);
    chk("tmr_words", accepted, 12);
    chk("tmr_done_pulses", done_cnt, 1);
`endif

    for (int r = 0; r < 6; r++) begin
      v.smax = $urandom_range(0, 9);
      v.rmode = 2;
      v.emode = 1;
      v.extra = $urandom_range(0, 3);
      v.exp_words = (v.smax + 1) * WPS;
      run_vec(v, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
